// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and defaults.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_MAX   = 32;

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// Prescaler: counts enabled cycles 0..DIV-1 and flags a tick on the last one.
module tick_divider #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    if (DIV < 1 || DIV > 255) begin : g_bad_div
        $error("tick_divider: DIV must be in 1..255");
    end

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt;

    assign tick = enable && !clear && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause, prescaled decrement and done/expired flags.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MAX   = DEF_MAX,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    if (MAX < 0 || MAX >= (1 << WIDTH)) begin : g_bad_max
        $error("countdown_timer: MAX must be below 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] clamped;
    logic             done_n;
    logic             active;
    logic             pre_en;
    logic             pre_clr;
    logic             tick;

    assign clamped = (load_value > MAXV) ? MAXV : load_value;
    assign active  = (state == RUN) || (state == PAUSED);

    // Resuming from PAUSED counts as a RUN cycle so a pause costs exactly its length.
    assign pre_en  = active && !load && !pause;
    assign pre_clr = load || !active;

    tick_divider #(
        .DIV(DIV)
    ) u_div (
        .clock (clock),
        .reset (reset),
        .enable(pre_en),
        .clear (pre_clr),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (load) begin
                    count_n = clamped;
                    if (start) state_n = (clamped != '0) ? RUN : DONE;
                end else if (start) begin
                    state_n = (count != '0) ? RUN : DONE;
                end
            end
            RUN, PAUSED: begin
                if (load) begin
                    count_n = clamped;
                    if (clamped == '0) state_n = DONE;
                end else if (pause) begin
                    state_n = PAUSED;
                end else begin
                    state_n = RUN;
                    if (tick && count != '0) begin
                        count_n = count - ONE;
                        if (count == ONE) state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (load) begin
                    count_n = clamped;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        done_n = (state_n == DONE) && (state != DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            done  <= done_n;
        end
    end

    assign busy    = active;
    assign expired = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: DIV=1 and DIV=4 timers on shared stimulus, hand-computed expectations.
module tb_countdown_timer;

    logic       clock;
    logic       reset;
    logic       load;
    logic [5:0] load_value;
    logic       start;
    logic       pause;

    logic [5:0] c1, c4;
    logic       b1, b4, d1, d4, e1, e4;

    int checks;
    int errors;

    countdown_timer #(.WIDTH(6), .MAX(32), .DIV(1)) u1 (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .count     (c1),
        .busy      (b1),
        .done      (d1),
        .expired   (e1)
    );

    countdown_timer #(.WIDTH(6), .MAX(32), .DIV(4)) u4 (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .count     (c4),
        .busy      (b4),
        .done      (d4),
        .expired   (e4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input int cnt, input int bsy,
                        input int dn, input int ex);
        chk({tag, ".count"}, 32'(c1), cnt);
        chk({tag, ".busy"}, 32'(b1), bsy);
        chk({tag, ".done"}, 32'(d1), dn);
        chk({tag, ".expired"}, 32'(e1), ex);
    endtask

    task automatic chk4(input string tag, input int cnt, input int bsy,
                        input int dn, input int ex);
        chk({tag, ".count"}, 32'(c4), cnt);
        chk({tag, ".busy"}, 32'(b4), bsy);
        chk({tag, ".done"}, 32'(d4), dn);
        chk({tag, ".expired"}, 32'(e4), ex);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        load = 1'b0;
        load_value = '0;
        start = 1'b0;
        pause = 1'b0;

        // reset state
        repeat (2) step();
        chk1("rst1", 0, 0, 0, 0);
        chk4("rst4", 0, 0, 0, 0);
        reset = 1'b1;

        // basic countdown, DIV=1
        load = 1'b1; load_value = 6'd3;
        step();
        load = 1'b0;
        chk1("ld3", 3, 0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("e2", 3, 1, 0, 0);
        step();
        chk1("e3", 2, 1, 0, 0);
        step();
        chk1("e4", 1, 1, 0, 0);
        step();
        chk1("e5", 0, 0, 1, 1);
        step();
        chk1("e6", 0, 0, 0, 1);

        // DONE ignores start; load returns to IDLE
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        chk1("dstart", 0, 0, 0, 1);
        load = 1'b1; load_value = 6'd7;
        step();
        load = 1'b0;
        chk1("dload", 7, 0, 0, 0);

        // clamp and zero start
        load = 1'b1; load_value = 6'd50;
        step();
        chk1("clamp", 32, 0, 0, 0);
        load_value = 6'd0; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        chk1("zero", 0, 0, 1, 1);
        step();
        chk1("zero2", 0, 0, 0, 1);

        // asynchronous reset mid-RUN
        load = 1'b1; load_value = 6'd6;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("r6", 6, 1, 0, 0);
        step();
        step();
        chk1("r4", 4, 1, 0, 0);
        #2 reset = 1'b0;
        #1 chk1("arst", 0, 0, 0, 0);
        step();
        chk1("arst2", 0, 0, 0, 0);
        #2 reset = 1'b1;

        // DIV=4 with a 3-cycle pause in mid-period
        load = 1'b1; load_value = 6'd2; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        chk4("p0", 2, 1, 0, 0);
        step();
        step();
        chk4("p2", 2, 1, 0, 0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk4("ph", 2, 1, 0, 0);
        end
        pause = 1'b0;
        step();
        chk4("p6", 2, 1, 0, 0);
        step();
        chk4("p7", 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk4("p8", 1, 1, 0, 0);
        end
        step();
        chk4("p11", 0, 0, 1, 1);

        // reload while RUN clears the prescaler
        load = 1'b1; load_value = 6'd3;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk4("rl2", 2, 1, 0, 0);
        step();
        step();
        load = 1'b1; load_value = 6'd5;
        step();
        load = 1'b0;
        chk4("rl5", 5, 1, 0, 0);
        repeat (3) step();
        chk4("rl5b", 5, 1, 0, 0);
        step();
        chk4("rl4", 4, 1, 0, 0);

        // reload with 0 while RUN goes straight to DONE
        load = 1'b1; load_value = 6'd0;
        step();
        load = 1'b0;
        chk4("rl0", 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the counter width in bits.
REQ-002 The block SHALL have parameter MAX, default 32, giving the largest loadable count.
REQ-003 The block SHALL have parameter DIV, default 1, range 1..255, giving the RUN clocks per decrement.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 Port load, input, 1 bit: when high, load_value is loaded into count at the next edge.
REQ-007 Port load_value, input, WIDTH bits: the initial count, clamped to MAX.
REQ-008 Port start, input, 1 bit: when high in IDLE, countdown begins.
REQ-009 Port pause, input, 1 bit: level; while high, RUN is suspended.
REQ-010 Port count, output, WIDTH bits: the current remaining count, registered.
REQ-011 Port busy, output, 1 bit: high in RUN or PAUSED.
REQ-012 Port done, output, 1 bit: a one-cycle pulse on the first cycle of DONE.
REQ-013 Port expired, output, 1 bit: level, high throughout DONE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN, PAUSED and DONE; all outputs SHALL be registered or decoded from registered state.
REQ-015 Load clamp: the loaded count SHALL be load_value if load_value <= MAX, otherwise MAX.
REQ-016 Priority at each edge SHALL be reset, then load, then start, then pause, then tick.
REQ-017 IDLE + load: the block SHALL load count; if start is also high and the clamped value is nonzero, it SHALL enter RUN at the same edge.
REQ-018 IDLE + start, count != 0: the block SHALL go to RUN with the prescaler cleared; no decrement SHALL occur on this edge.
REQ-019 IDLE + start, count == 0 (also load+start with clamped 0): the block SHALL go directly to DONE.
REQ-020 The prescaler SHALL count RUN cycles 0..DIV-1; a tick SHALL occur when it equals DIV-1, and the prescaler SHALL then wrap to 0.
REQ-021 RUN + tick: count SHALL decrement by 1; when it reaches 0, the block SHALL go to DONE at that same edge, and count SHALL never wrap below 0.
REQ-022 RUN + pause: the block SHALL go to PAUSED; count and prescaler SHALL freeze, with no tick on that edge.
REQ-023 PAUSED + pause low: the block SHALL return to RUN and resume the prescaler from its frozen value.
REQ-024 RUN/PAUSED + load: the block SHALL reload count and clear the prescaler while keeping its state; if the clamped value is 0, it SHALL go to DONE.
REQ-025 DONE: count SHALL read 0 and expired SHALL read 1; done SHALL be high only on the first DONE cycle.
REQ-026 DONE + load: the block SHALL load count and go to IDLE; start or pause in DONE SHALL be ignored.
REQ-027 Width rule: MAX SHALL satisfy MAX < 2^WIDTH, and the block SHALL reject a violating parameter set at elaboration.

Reset
REQ-028 While reset = 0: state SHALL be IDLE, with count=0, prescaler=0, busy=0, done=0 and expired=0.
REQ-029 A reset asserted mid-RUN SHALL abort immediately with no done pulse.
REQ-030 After reset release, the first edge SHALL evaluate inputs normally.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3) and the default WIDTH/MAX constants.
REQ-032 The prescaler SHALL be a separate sub-module, tick_divider (inputs clock, reset, enable, clear; output tick).
REQ-033 The counter and FSM SHALL reside in countdown_timer.

Verification
REQ-034 With DIV=1: load=1, value 3 at edge 1; start at edge 2 -> count 3,2,1,0 after edges 2,3,4,5; done=1 only after edge 5; expired stays 1.
REQ-035 load_value=50 -> count=32; load_value=0 with start -> DONE next edge, done pulse, count 0.
REQ-036 With DIV=4 and load 2: decrements SHALL occur every 4th RUN edge; pause held 3 cycles mid-period shall delay expiry by exactly 3 cycles.
REQ-037 Reload: load 5 while RUN at count 2 -> count=5, prescaler 0, busy stays 1.
REQ-038 reset=0 asynchronously while RUN at count 4 -> all outputs 0 before the next edge, state IDLE, no done pulse.
REQ-039 In DONE, start=1 -> no change; load 7 -> IDLE, count 7, expired 0.
